bitty_fetch_ctrl: RTL
=====================

// Module: bitty_fetch_ctrl
// PURPOSE
//   Instruction sequencer for the bitty core. Fetches 16-bit words from program
//   memory, drives d_instr and pulses run, then waits for done. Resolves branch
//   and halt opcodes locally, and tracks the PC. Sits between program memory and bitty.
// PARAMETERS
//   ADDR_W   8    program-memory address width; PC wraps modulo 2**ADDR_W
//   TIMEOUT  255  max cycles in WAIT for done before entering ERROR (8-bit counter)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   reset      in   1       asynchronous, active-low; 0 forces reset state immediately
//   start      in   1       level; sampled in IDLE/HALTED, begins execution at PC=start_pc
//   start_pc   in   ADDR_W  entry address loaded on accepted start
//   halt_req   in   1       level; stop after the in-flight instruction completes
//   mem_addr   out  ADDR_W  program-memory address (= PC)
//   mem_rd     out  1       read request, held high until mem_valid
//   mem_rdata  in   16      instruction word, valid when mem_valid=1
//   mem_valid  in   1       read-data strobe, latency >= 1 cycle after mem_rd
//   instr      out  16      to bitty d_instr; stable from ISSUE until done
//   run        out  1       one-cycle pulse to bitty per issued instruction
//   done       in   1       bitty completion pulse
//   result     in   16      bitty d_out, captured when done=1
//   pc         out  ADDR_W  current PC
//   busy       out  1       1 in FETCH/DECODE/ISSUE/WAIT
//   halted     out  1       1 in HALTED
//   error      out  1       1 in ERROR (done timeout); sticky until reset
// BEHAVIOUR
//   Reset: state=IDLE; pc, instr, mem_addr, last_result, wdog = 0; mem_rd, run, busy,
//     halted, error = 0.
//   IDLE: start=1 -> pc<=start_pc, FETCH. HALTED: same on start; halted=1 otherwise.
//   FETCH: mem_rd=1, mem_addr=pc. On mem_valid: ir<=mem_rdata, DECODE.
//     mem_valid outside FETCH is ignored.
//   DECODE (1 cycle):
//     ir==16'hFFFF (HALT) -> HALTED, pc unchanged.
//     ir[1:0]==2'b10 (BRANCH), not issued to core. cond=ir[3:2] on last_result:
//       00 ==0; 01 signed >0; 10 signed <0; 11 never.
//       Taken -> pc<=ir[4+ADDR_W-1:4]; else pc<=pc+1. Then FETCH, or HALTED if halt_req.
//     Otherwise -> instr<=ir, ISSUE.
//   ISSUE (1 cycle): run=1, wdog<=0 -> WAIT.
//   WAIT: wdog increments each cycle.
//     done=1 -> last_result<=result, pc<=pc+1, then HALTED if halt_req else FETCH.
//     wdog==TIMEOUT with no done -> ERROR.
//     A done arriving in the same cycle the counter hits TIMEOUT wins.
//   ERROR: error=1, run=0, mem_rd=0; exit only via reset.
//   done outside WAIT is ignored. start while busy is ignored.
//   PC wraps: 2**ADDR_W-1 +1 -> 0.
//   Fetch-to-run latency with 1-cycle memory: mem_rd at T, valid T+1, DECODE T+2,
//     run at T+3.
//   Reset mid-operation: immediate return to reset values. The in-flight bitty op
//     is abandoned; bitty shares the same reset.
// TESTING
//   1. Reset; start=1, start_pc=8'h10, memory[10]=16'h0041, 1-cycle mem, done 4 cycles
//      after run -> mem_addr=10, run pulses once, instr=0041 until done, pc=11, FETCH.
//   2. memory[11]=FFFF after case 1 -> HALTED, halted=1, pc=11, no run pulse.
//   3. Branch: last_result=0, ir=16'h0202 (BEQ, target 8'h20) -> pc=20, no run.
//      Repeat with last_result=16'h8000 and cond 01 -> not taken, pc=pc+1.
//   4. pc=8'hFF, normal instruction completes -> pc=00, next mem_addr=00.
//   5. done never returned, TIMEOUT=255 -> error=1 exactly 255 cycles after WAIT entry;
//      start ignored; reset clears error.
//   6. halt_req raised during WAIT -> after done, pc+1 then HALTED with no further fetch.
//      Reset asserted in WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bitty_fetch_ctrl.sv
// Instruction sequencer for bitty: fetches words, resolves branch/halt locally, issues the rest and awaits done.
// Latency: run 3 cycles after mem_rd with 1-cycle memory; mem_rd held until mem_valid; done watchdog trips TIMEOUT cycles after WAIT entry.
module bitty_fetch_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instr,
  output logic              run,
  input  logic              done,
  input  logic [15:0]       result,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam logic [7:0]        WDOG_LIMIT = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       last_q, last_d;
  logic [7:0]        wdog_q, wdog_d;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  assign br_target = ir_q[4 +: ADDR_W];

  // Branch condition is evaluated on the result of the last issued instruction.
  always_comb begin
    case (ir_q[3:2])
      2'b00:   br_taken = (last_q == 16'd0);
      2'b01:   br_taken = ($signed(last_q) > 16'sd0);
      2'b10:   br_taken = last_q[15];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    instr_d = instr_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_valid) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == 16'hFFFF) begin
          state_d = S_HALTED;
        end else if (ir_q[1:0] == 2'b10) begin
          pc_d    = br_taken ? br_target : pc_q + PC_ONE;
          state_d = halt_req ? S_HALTED : S_FETCH;
        end else begin
          instr_d = ir_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the last allowed cycle takes priority over the timeout.
        wdog_d = wdog_q + 8'd1;
        if (done) begin
          last_d  = result;
          pc_d    = pc_q + PC_ONE;
          state_d = halt_req ? S_HALTED : S_FETCH;
        end else if (wdog_d == WDOG_LIMIT) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 16'd0;
      instr_q <= 16'd0;
      last_q  <= 16'd0;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;
  assign instr    = instr_q;
  assign mem_rd   = (state_q == S_FETCH);
  assign run      = (state_q == S_ISSUE);
  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted   = (state_q == S_HALTED);
  assign error    = (state_q == S_ERROR);

endmodule
